// File: rtl/noc_crossbar.sv
`default_nettype none
// ============================================================================
// Module      : noc_crossbar
// Description : P x P flit crossbar between the input-port buffers and the
//               output links of a NoC router. Each input presents one flit
//               and a (P-1)-bit one-hot grant naming the output it won. The
//               crossbar steers the flit there and raises that output's
//               write enable. SSA write requests can be OR-ed into the
//               enables, and the outputs can be registered.
// Ports       : clk                   - clock (registered variant only)
//               reset                 - async active-high reset (registered variant only)
//               granted_dest_port_all - per input i, bits [i*(P-1) +: P-1]
//               flit_in_all           - per input i, bits [i*Fw +: Fw]
//               ssa_flit_wr_all       - per output o, SSA write request
//               flit_out_all          - per output o, bits [o*Fw +: Fw]
//               flit_out_we_all       - per output o, flit valid strobe
// Revision    : 1.0 - initial release
// ============================================================================
module noc_crossbar #(
  parameter     TOPOLOGY                  = "MESH",
  parameter int V                         = 4,
  parameter int P                         = 5,
  parameter int Fpay                      = 32,
  parameter     MUX_TYPE                  = "ONE_HOT",
  parameter int ADD_PIPREG_AFTER_CROSSBAR = 0,
  parameter     SSA_EN                    = "YES"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [P*(P-1)-1:0]            granted_dest_port_all,
  input  logic [P*(2+V+Fpay)-1:0]       flit_in_all,
  input  logic [P-1:0]                  ssa_flit_wr_all,
  output logic [P*(2+V+Fpay)-1:0]       flit_out_all,
  output logic [P-1:0]                  flit_out_we_all
);

  localparam int c_fw   = 2 + V + Fpay;
  localparam int c_selw = $clog2(P);

  // Topology has no effect on steering; it is only carried for compatibility.
  logic w_unused_topology;
  assign w_unused_topology = (TOPOLOGY == "MESH");

  logic [P-1:0]      w_g       [P];   // w_g[i][o]: input i drives output o
  logic [c_fw-1:0]   w_flit_in [P];
  logic [c_fw-1:0]   w_mux     [P];
  logic [P-1:0]      w_ssa;
  logic [P-1:0]      w_we;
  logic [P*c_fw-1:0] w_flit_d;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_unpack
      assign w_flit_in[gi]                 = flit_in_all[gi*c_fw +: c_fw];
      assign w_flit_d[gi*c_fw +: c_fw]     = w_mux[gi];
    end
  endgenerate

  // A grant vector omits the input's own port, so local bit j maps to
  // output j below the input index and to output j+1 at or above it.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      w_g[i] = '0;
      for (int j = 0; j < P-1; j++) begin
        if (j < i) w_g[i][j]   = granted_dest_port_all[i*(P-1)+j];
        else       w_g[i][j+1] = granted_dest_port_all[i*(P-1)+j];
      end
    end
  end

  generate
    if (SSA_EN == "YES") begin : g_ssa_on
      assign w_ssa = ssa_flit_wr_all;
    end else begin : g_ssa_off
      logic w_unused_ssa;
      assign w_unused_ssa = |ssa_flit_wr_all;
      assign w_ssa        = '0;
    end
  endgenerate

  always_comb begin
    for (int o = 0; o < P; o++) begin
      w_we[o] = w_ssa[o];
      for (int i = 0; i < P; i++) w_we[o] = w_we[o] | w_g[i][o];
    end
  end

  generate
    if (MUX_TYPE == "BINARY") begin : g_mux_binary
      logic [c_selw-1:0] w_sel [P];
      logic [P-1:0]      w_hit;
      // Scan from the top so the lowest-index granting input wins a conflict.
      always_comb begin
        for (int o = 0; o < P; o++) begin
          w_sel[o] = '0;
          w_hit[o] = 1'b0;
          for (int i = P-1; i >= 0; i--) begin
            if (w_g[i][o]) begin
              w_sel[o] = c_selw'(i);
              w_hit[o] = 1'b1;
            end
          end
          w_mux[o] = w_hit[o] ? w_flit_in[w_sel[o]] : '0;
        end
      end
    end else begin : g_mux_onehot
      // AND-OR mux: conflicting grants OR their flits together.
      always_comb begin
        for (int o = 0; o < P; o++) begin
          w_mux[o] = '0;
          for (int i = 0; i < P; i++)
            w_mux[o] = w_mux[o] | (w_flit_in[i] & {c_fw{w_g[i][o]}});
        end
      end
    end
  endgenerate

  generate
    if (ADD_PIPREG_AFTER_CROSSBAR != 0) begin : g_out_reg
      logic [P*c_fw-1:0] flit_out_q;
      logic [P-1:0]      we_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          flit_out_q <= '0;
          we_q       <= '0;
        end else begin
          flit_out_q <= w_flit_d;
          we_q       <= w_we;
        end
      end
      assign flit_out_all    = flit_out_q;
      assign flit_out_we_all = we_q;
    end else begin : g_out_comb
      logic w_unused_clkrst;
      assign w_unused_clkrst = clk ^ reset;
      assign flit_out_all    = w_flit_d;
      assign flit_out_we_all = w_we;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_noc_crossbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_crossbar
// Description : Self-checking bench for noc_crossbar. Four instances share
//               one stimulus: ONE_HOT comb, BINARY comb, ONE_HOT comb with
//               SSA ignored, and BINARY registered. Expectations come from
//               a per-output reference model built from the routing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_crossbar;

  localparam int P    = 5;
  localparam int V    = 4;
  localparam int FPAY = 32;
  localparam int FW   = 2 + V + FPAY;
  localparam int GW   = P * (P - 1);
  localparam int ND   = 4;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [GW-1:0]   grant = '0;
  logic [P*FW-1:0] fin   = '0;
  logic [P-1:0]    ssa   = '0;

  logic [P*FW-1:0] fo  [ND];
  logic [P-1:0]    we  [ND];
  logic [P*FW-1:0] efo [ND];
  logic [P-1:0]    ewe [ND];
  string           dn  [ND] = '{"onehot", "binary", "nossa", "pipe"};

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  noc_crossbar #(.V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("ONE_HOT"),
                 .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("YES")) u_oh (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(fin),
    .ssa_flit_wr_all(ssa), .flit_out_all(fo[0]), .flit_out_we_all(we[0]));

  noc_crossbar #(.V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("BINARY"),
                 .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("YES")) u_bin (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(fin),
    .ssa_flit_wr_all(ssa), .flit_out_all(fo[1]), .flit_out_we_all(we[1]));

  noc_crossbar #(.V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("ONE_HOT"),
                 .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("NO")) u_nossa (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(fin),
    .ssa_flit_wr_all(ssa), .flit_out_all(fo[2]), .flit_out_we_all(we[2]));

  noc_crossbar #(.V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("BINARY"),
                 .ADD_PIPREG_AFTER_CROSSBAR(1), .SSA_EN("YES")) u_pipe (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(fin),
    .ssa_flit_wr_all(ssa), .flit_out_all(fo[3]), .flit_out_we_all(we[3]));

  // Local grant bit that input i uses to name output o (o != i).
  function automatic int lbit(int i, int o);
    return (o < i) ? o : o - 1;
  endfunction

  // Reference: for each output, gather every input whose grant names it.
  task automatic ref_model(input logic [GW-1:0] gr, input logic [P*FW-1:0] fi,
                           input logic [P-1:0] ss, input bit binary, input bit ssa_en,
                           output logic [P*FW-1:0] xo, output logic [P-1:0] xwe);
    xo  = '0;
    xwe = ssa_en ? ss : '0;
    for (int o = 0; o < P; o++) begin
      bit found = 0;
      for (int i = 0; i < P; i++) begin
        if (i != o && gr[i*(P-1) + lbit(i, o)]) begin
          xwe[o] = 1'b1;
          if (!binary)    xo[o*FW +: FW] = xo[o*FW +: FW] | fi[i*FW +: FW];
          else if (!found) xo[o*FW +: FW] = fi[i*FW +: FW];
          found = 1;
        end
      end
    end
  endtask

  task automatic model_comb();
    ref_model(grant, fin, ssa, 1'b0, 1'b1, efo[0], ewe[0]);
    ref_model(grant, fin, ssa, 1'b1, 1'b1, efo[1], ewe[1]);
    ref_model(grant, fin, ssa, 1'b0, 1'b0, efo[2], ewe[2]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    grant = '0;
    grant[0*(P-1) + lbit(0, 1)] = 1'b1;
    fin   = '0;
    fin[0*FW +: FW] = 38'h15_5555_5555;
    ssa   = 5'b00100;
    repeat (2) step();
    total++;
    if (fo[3] !== '0 || we[3] !== '0)
      $display("FAIL reset_pipe got we=%b fo=%h want all zero", we[3], fo[3]);
    else passed++;
    model_comb();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (fo[d] !== efo[d] || we[d] !== ewe[d])
        $display("FAIL reset_comb dut=%s got we=%b fo=%h want we=%b fo=%h", dn[d], we[d], fo[d], ewe[d], efo[d]);
      else passed++;
    end
    grant = '0; fin = '0; ssa = '0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    grant = '0; ssa = '0; fin = '0;
    grant[0*(P-1) + 0] = 1'b1;
    fin[0*FW +: FW] = 38'h1_2345_6789;
    #1;
    model_comb();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (fo[d] !== efo[d] || we[d] !== ewe[d])
        $display("FAIL single dut=%s got we=%b fo=%h want we=%b fo=%h", dn[d], we[d], fo[d], ewe[d], efo[d]);
      else passed++;
    end
    total++;
    if (we[0] !== 5'b00010 || fo[0][1*FW +: FW] !== 38'h1_2345_6789)
      $display("FAIL single_out1 got we=%b out1=%h want we=00010 out1=0123456789", we[0], fo[0][1*FW +: FW]);
    else passed++;
    step();
  endtask

  task automatic test_permutation();
    grant = '0; ssa = '0;
    for (int i = 0; i < P; i++) fin[i*FW +: FW] = FW'({$urandom(), $urandom()});
    grant[1*(P-1) + lbit(1, 0)] = 1'b1;
    grant[2*(P-1) + lbit(2, 3)] = 1'b1;
    grant[4*(P-1) + lbit(4, 2)] = 1'b1;
    #1;
    model_comb();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (fo[d] !== efo[d] || we[d] !== ewe[d])
        $display("FAIL perm dut=%s got we=%b fo=%h want we=%b fo=%h", dn[d], we[d], fo[d], ewe[d], efo[d]);
      else passed++;
    end
    total++;
    if (we[1] !== 5'b01101 || fo[1][3*FW +: FW] !== fin[2*FW +: FW])
      $display("FAIL perm_out3 got we=%b out3=%h want we=01101 out3=%h", we[1], fo[1][3*FW +: FW], fin[2*FW +: FW]);
    else passed++;
    step();
  endtask

  task automatic test_ssa();
    grant = '0;
    ssa   = 5'b10000;
    for (int i = 0; i < P; i++) fin[i*FW +: FW] = FW'({$urandom(), $urandom()}) | FW'(1);
    #1;
    total++;
    if (we[0] !== 5'b10000 || fo[0] !== '0)
      $display("FAIL ssa_yes got we=%b fo=%h want we=10000 fo=0", we[0], fo[0]);
    else passed++;
    total++;
    if (we[2] !== 5'b00000 || fo[2] !== '0)
      $display("FAIL ssa_no got we=%b fo=%h want we=00000 fo=0", we[2], fo[2]);
    else passed++;
    ssa = '0;
    step();
  endtask

  task automatic test_pipeline();
    logic [FW-1:0] f;
    f = FW'({$urandom(), $urandom()}) | FW'(1);
    grant = '0; ssa = '0; fin = '0;
    step();
    grant[3*(P-1) + lbit(3, 0)] = 1'b1;
    fin[3*FW +: FW] = f;
    #1;
    total++;
    if (fo[3] !== '0 || we[3] !== '0)
      $display("FAIL pipe_early got we=%b fo=%h want zero before the edge", we[3], fo[3]);
    else passed++;
    step();
    grant = '0;
    total++;
    if (we[3] !== 5'b00001 || fo[3][0 +: FW] !== f || fo[3][P*FW-1:FW] !== '0)
      $display("FAIL pipe_latency got we=%b fo=%h want we=00001 out0=%h", we[3], fo[3], f);
    else passed++;
    step();
    total++;
    if (fo[3] !== '0 || we[3] !== '0)
      $display("FAIL pipe_one_cycle got we=%b fo=%h want zero", we[3], fo[3]);
    else passed++;
    grant[3*(P-1) + lbit(3, 0)] = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    total++;
    if (fo[3] !== '0 || we[3] !== '0)
      $display("FAIL pipe_async_reset got we=%b fo=%h want zero", we[3], fo[3]);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if (fo[3] !== '0 || we[3] !== '0)
      $display("FAIL pipe_post_reset got we=%b fo=%h want zero", we[3], fo[3]);
    else passed++;
    step();
    total++;
    if (we[3] !== 5'b00001 || fo[3][0 +: FW] !== f)
      $display("FAIL pipe_first_valid got we=%b out0=%h want we=00001 out0=%h", we[3], fo[3][0 +: FW], f);
    else passed++;
    grant = '0;
    step();
  endtask

  task automatic test_conflict();
    grant = '0; ssa = '0; fin = '0;
    grant[0*(P-1) + lbit(0, 1)] = 1'b1;
    grant[2*(P-1) + lbit(2, 1)] = 1'b1;
    fin[0*FW +: FW] = 38'hA5;
    fin[2*FW +: FW] = 38'h5A;
    #1;
    total++;
    if (fo[0][1*FW +: FW] !== 38'hFF || we[0] !== 5'b00010)
      $display("FAIL conflict_onehot got we=%b out1=%h want we=00010 out1=ff", we[0], fo[0][1*FW +: FW]);
    else passed++;
    total++;
    if (fo[1][1*FW +: FW] !== 38'hA5 || we[1] !== 5'b00010)
      $display("FAIL conflict_binary got we=%b out1=%h want we=00010 out1=a5", we[1], fo[1][1*FW +: FW]);
    else passed++;
    step();
  endtask

  task automatic test_random();
    int perm [P];
    int tmp, j;
    logic [P*FW-1:0] pfo;
    logic [P-1:0]    pwe;
    int bad_cmp, bad_self;
    bad_cmp = 0; bad_self = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) begin
        total++;
        if (fo[3] !== pfo || we[3] !== pwe) begin
          $display("FAIL rand_pipe cycle=%0d got we=%b fo=%h want we=%b fo=%h", k, we[3], fo[3], pwe, pfo);
          bad_cmp++;
        end else passed++;
      end
      for (int i = 0; i < P; i++) perm[i] = i;
      for (int i = P - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      grant = '0;
      for (int i = 0; i < P; i++) begin
        logic [FW-1:0] f;
        f = FW'({$urandom(), $urandom()});
        f[2:0] = 3'(i);  // source tag, used to spot a U-turn
        fin[i*FW +: FW] = f;
        if (perm[i] != i && $urandom_range(0, 3) != 0)
          grant[i*(P-1) + lbit(i, perm[i])] = 1'b1;
      end
      ssa = ($urandom_range(0, 3) == 0) ? P'($urandom()) : '0;
      #1;
      model_comb();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (fo[d] !== efo[d] || we[d] !== ewe[d]) begin
          $display("FAIL rand dut=%s cycle=%0d got we=%b fo=%h want we=%b fo=%h", dn[d], k, we[d], fo[d], ewe[d], efo[d]);
          bad_cmp++;
        end else passed++;
      end
      for (int o = 0; o < P; o++) begin
        bit granted = 0;
        for (int i = 0; i < P; i++)
          if (i != o && grant[i*(P-1) + lbit(i, o)]) granted = 1;
        if (granted) begin
          total++;
          if (fo[0][o*FW +: 3] == 3'(o) || fo[1][o*FW +: 3] == 3'(o)) begin
            $display("FAIL rand_uturn cycle=%0d out=%0d onehot_tag=%0d binary_tag=%0d want tag!=%0d", k, o, fo[0][o*FW +: 3], fo[1][o*FW +: 3], o);
            bad_self++;
          end else passed++;
        end
      end
      ref_model(grant, fin, ssa, 1'b1, 1'b1, pfo, pwe);
      step();
    end
    total++;
    if (fo[3] !== pfo || we[3] !== pwe)
      $display("FAIL rand_pipe_last got we=%b fo=%h want we=%b fo=%h", we[3], fo[3], pwe, pfo);
    else passed++;
    grant = '0; ssa = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d passed=%0d", total, passed);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_permutation();
    test_ssa();
    test_pipeline();
    test_conflict();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
